// File: rtl/io_uart_tx_pkg.sv
// Shared definitions for the IO-mapped UART transmitter: FSM state encoding
// and the default bit timing (115200 baud from a 100 MHz clock).
package io_uart_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO with combinational head read; push and pop may coincide even when
// full because the head is consumed before the shared slot is overwritten.
module io_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign rdata = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter (8N1): processor stores land in a byte FIFO
// and are serialised LSB first, back-to-back while bytes remain queued.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  io_data,
  input  logic                        io_write,
  output logic                        io_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    head;
  logic          pending;
  logic          bit_end;
  logic          pop;
  logic          push;

  assign bit_end  = (baud == BAUD_LAST);
  assign io_ready = (fifo_count < FULL_CNT);

  // Leaving IDLE waits on the registered FIFO level; the end of a stop bit
  // chains straight into the next start bit off the live count.
  assign pop  = (fifo_count != '0) &&
                ((state == ST_IDLE && pending) || (state == ST_STOP && bit_end));
  assign push = io_write && (io_ready || pop);

  io_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (io_data),
    .rdata (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (io_write && !push) overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      pending <= 1'b0;
    end else begin
      pending <= (fifo_count != '0);
      case (state)
        ST_IDLE: begin
          baud <= '0;
          if (pop) begin
            state <= ST_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shreg[0];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          baud  <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shift register keeps the next data bit in position 0.
  always_ff @(posedge clk) begin
    if (pop) shreg <= head;
    else if (bit_end && (state == ST_START || state == ST_DATA)) shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: directed scenarios plus random traffic, all compared
// each cycle against a frame-level model of queue, line and status.
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] io_data;
  logic       io_write;
  logic       io_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .io_data    (io_data),
    .io_write   (io_write),
    .io_ready   (io_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: queued bytes with the edge they were accepted on,
  // plus the frame currently on the line and its cycle position.
  logic [7:0] mq[$];
  int         mt[$];
  int         edge_no = 0;
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 0;

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    if (m_pos < CPB) return 1'b0;
    if (m_pos < 9 * CPB) return m_cur[(m_pos - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string name);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mt.delete();
    m_active = 0;
    m_pos    = 0;
    m_ovf    = 0;
  endtask

  task automatic model_edge(input bit w, input logic [7:0] d);
    bit do_pop;
    bit acc;
    bit frame_end;
    edge_no++;
    frame_end = m_active && (m_pos == FRAME - 1);
    do_pop = 0;
    if (frame_end) do_pop = (mq.size() > 0);
    else if (!m_active && mq.size() > 0 && edge_no >= mt[0] + 2) do_pop = 1;
    acc = w && (mq.size() < DEPTH || do_pop);
    if (w && !acc) m_ovf = 1;
    if (frame_end && !do_pop) m_active = 0;
    else if (m_active) m_pos++;
    if (do_pop) begin
      m_cur = mq.pop_front();
      void'(mt.pop_front());
      m_active = 1;
      m_pos    = 0;
    end
    if (acc) begin
      mq.push_back(d);
      mt.push_back(edge_no);
    end
  endtask

  task automatic check_all(input string tag);
    chk(32'(tx),         32'(exp_tx()),            {tag, "/tx"});
    chk(32'(busy),       32'(m_active),            {tag, "/busy"});
    chk(32'(fifo_count), 32'(mq.size()),           {tag, "/count"});
    chk(32'(overflow),   32'(m_ovf),               {tag, "/overflow"});
    chk(32'(io_ready),   32'(mq.size() < DEPTH),   {tag, "/io_ready"});
  endtask

  task automatic step(input bit w, input logic [7:0] d, input string tag);
    io_write = w;
    io_data  = d;
    @(posedge clk);
    model_edge(w, d);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk(32'(tx),         32'd1, {tag, "/rst_tx"});
    chk(32'(busy),       32'd0, {tag, "/rst_busy"});
    chk(32'(fifo_count), 32'd0, {tag, "/rst_count"});
    chk(32'(overflow),   32'd0, {tag, "/rst_overflow"});
    @(posedge clk);
    @(negedge clk);
    check_all({tag, "/in_reset"});
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] rx;
    int         peak;
    int         busy_cyc;
    int         zeros;
    int         prob;
    a5       = 8'hA5;
    reset    = 1'b1;
    io_write = 1'b0;
    io_data  = 8'h00;

    // Reset state
    @(negedge clk);
    #1;
    chk(32'(tx),         32'd1, "init/tx");
    chk(32'(busy),       32'd0, "init/busy");
    chk(32'(fifo_count), 32'd0, "init/count");
    chk(32'(overflow),   32'd0, "init/overflow");
    chk(32'(io_ready),   32'd1, "init/io_ready");
    reset = 1'b0;

    // Single byte 0xA5 into an idle block
    step(1'b1, 8'hA5, "a5_wr");
    for (int i = 1; i <= 44; i++) begin
      step(1'b0, 8'h00, "a5");
      if (i == 1) chk(32'(tx), 32'd1, "a5_fall_early");
      if (i == 2) chk(32'(tx), 32'd0, "a5_fall");
      if (i >= 6 && i <= 37) chk(32'(tx), 32'(a5[(i - 6) / 4]), "a5_bit");
      if (i >= 38 && i <= 41) chk(32'(tx), 32'd1, "a5_stop");
      if (i == 41) chk(32'(busy), 32'd1, "a5_busy_hold");
      if (i == 42) chk(32'(busy), 32'd0, "a5_busy_end");
    end

    // Three back-to-back frames
    peak = 0;
    busy_cyc = 0;
    for (int i = 0; i < 133; i++) begin
      if (i < 3) step(1'b1, 8'(i + 1), "b2b_wr");
      else       step(1'b0, 8'h00, "b2b");
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (busy) busy_cyc++;
    end
    chk(32'(peak), 32'd2, "b2b_peak");
    chk(32'(busy_cyc), 32'd120, "b2b_busy_cycles");

    // io_data wiggling mid-frame must not disturb the byte in flight
    rx = 8'h00;
    step(1'b1, 8'h3C, "hold_wr");
    for (int i = 1; i <= 44; i++) begin
      step(1'b0, 8'($urandom), "hold");
      if (i >= 8 && ((i - 8) % 4 == 0) && (i - 8) / 4 < 8) rx[(i - 8) / 4] = tx;
    end
    chk(32'(rx), 32'h3C, "hold_byte");
    chk(32'(fifo_count), 32'd0, "hold_count");

    // Six writes: one popped, four queued, sixth dropped
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), "ovf_wr");
    chk(32'(overflow), 32'd1, "ovf_set");
    chk(32'(io_ready), 32'd0, "ovf_full_ready");
    chk(32'(fifo_count), 32'd4, "ovf_full_count");
    for (int i = 0; i < 400 && (m_active || mq.size() > 0); i++) step(1'b0, 8'h00, "ovf_drain");
    chk(32'(overflow), 32'd1, "ovf_sticky");
    chk(32'(busy), 32'd0, "ovf_drained");

    // Reset in the middle of DATA of 0xFF with two queued
    do_reset("clr");
    step(1'b1, 8'hFF, "rmid_wr");
    step(1'b1, 8'h11, "rmid_wr");
    step(1'b1, 8'h22, "rmid_wr");
    chk(32'(fifo_count), 32'd2, "rmid_queued");
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, "rmid_run");
    chk(32'(tx), 32'd1, "rmid_data_bit");
    do_reset("rmid");
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00, "rmid_quiet");
      if (tx == 1'b0 || busy) zeros++;
    end
    chk(32'(zeros), 32'd0, "rmid_no_frame");

    // Write to a full FIFO on the same edge as the stop-end pop
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), "fullpop_fill");
    for (int i = 0; i < 100 && !(m_active && m_pos == FRAME - 1); i++) step(1'b0, 8'h00, "fullpop_wait");
    chk(32'(io_ready), 32'd0, "fullpop_ready_low");
    chk(32'(fifo_count), 32'd4, "fullpop_full");
    step(1'b1, 8'h77, "fullpop_wr");
    chk(32'(fifo_count), 32'd4, "fullpop_count");
    chk(32'(overflow), 32'd0, "fullpop_no_ovf");
    chk(32'(tx), 32'd0, "fullpop_next_start");
    for (int i = 0; i < 400 && (m_active || mq.size() > 0); i++) step(1'b0, 8'h00, "fullpop_drain");

    // Random traffic with varying write density and one async reset
    for (int blk = 0; blk < 6; blk++) begin
      prob = $urandom_range(0, 100);
      for (int i = 0; i < 500; i++) begin
        if (blk == 3 && i == 217) do_reset("rnd_rst");
        step(($urandom_range(0, 99) < prob), 8'($urandom), "rnd");
      end
    end
    for (int i = 0; i < 400 && (m_active || mq.size() > 0); i++) step(1'b0, 8'h00, "rnd_drain");
    chk(32'(busy), 32'd0, "rnd_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (legal >= 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries buffered (power of 2, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port io_data  input  8  byte written by the processor's memory-mapped IO store.
REQ-006 SHALL have port io_write  input  1  one-cycle strobe; io_data valid when high.
REQ-007 SHALL have port io_ready  output  1  high when the FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  registered serial line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in flight.
REQ-011 SHALL have port overflow  output  1  sticky flag; a write was dropped.
REQ-012 SHALL use clk and reset as the port names; reset is asynchronous, active-high, fixed.

Function
REQ-013 SHALL accept a write on an edge where io_write=1 and (fifo_count<FIFO_DEPTH, or a pop occurs on the same edge).
REQ-014 SHALL drop a write when full with no simultaneous pop, leave FIFO contents unchanged, and set overflow=1 until reset.
REQ-015 SHALL drive io_ready = (fifo_count<FIFO_DEPTH) combinationally.
REQ-016 SHALL keep fifo_count unchanged on a simultaneous accepted push and pop.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 SHALL pop the FIFO head into an 8-bit shift register in IDLE when fifo_count>0 and go to START; tx=0 on that edge.
REQ-019 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every state/bit change.
REQ-020 SHALL send DATA LSB first, bits 0..7, using a 3-bit index that wraps 7->0 on exit to STOP.
REQ-021 SHALL drive tx=1 for one bit-time in STOP.
REQ-022 SHALL, at the end of STOP, pop and go directly to START if fifo_count>0, with no idle cycle; otherwise go to IDLE.
REQ-023 SHALL make a frame 10*CLKS_PER_BIT cycles from the tx fall to the end of the stop bit.
REQ-024 SHALL produce the first tx fall on the 2nd rising edge after the edge that accepts a write into an empty, idle block.
REQ-025 SHALL not change the byte in flight when io_data or io_write change mid-frame.
REQ-026 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, while reset=1, immediately force tx=1, busy=0, state IDLE, fifo_count=0, overflow=0, baud counter=0, and pointers=0.
REQ-028 SHALL abandon any frame in progress when reset asserts and discard all queued bytes.
REQ-029 SHALL start operation on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place FSM state encodings and the default CLKS_PER_BIT in the shared defines include file, alongside the existing opcode one-hot defines.
REQ-031 SHALL implement the FIFO as one sub-module, io_byte_fifo, providing push, pop, data, and count.
REQ-032 SHALL contain the FSM, baud counter, and shift register in io_uart_tx itself.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 SHALL cover: single write 0xA5 to idle block -> tx fall 2 edges later; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high; busy low after 40 cycles.
REQ-034 SHALL cover: writes 0x01,0x02,0x03 on consecutive cycles -> three back-to-back frames (120 cycles) with no idle gap; fifo_count peaks at 2.
REQ-035 SHALL cover: 6 writes on consecutive cycles (first popped) -> 5 accepted, 6th dropped, io_ready=0 while full, overflow=1 thereafter.
REQ-036 SHALL cover: full FIFO plus a write coinciding with the STOP-end pop -> write accepted, fifo_count stays 4, overflow stays 0.
REQ-037 SHALL cover: reset asserted mid-DATA of 0xFF with 2 queued -> tx=1 immediately; count 0; no further frames after release until a new write.
REQ-038 SHALL cover: io_data toggling during a frame without io_write -> transmitted byte unchanged, fifo_count unchanged.
